// File: rtl/reservation_station_if.sv
// Handshake and data bundle between decode/forwarding/execute and the reservation station.
// The master modport drives everything the station consumes; the slave modport is the station itself.
interface reservation_station_if #(
    parameter int CNT_W = 3
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [115:0]     in_inst;
    logic [4:0]       in_rs1_tag;
    logic [4:0]       in_rs2_tag;
    logic             fwd_valid;
    logic [4:0]       fwd_addr;
    logic [31:0]      fwd_data;
    logic             issue_valid;
    logic             issue_ready;
    logic [31:0]      issue_aluin1;
    logic [31:0]      issue_aluin2;
    logic [31:0]      issue_memdata;
    logic [12:0]      issue_ctrl;
    logic [4:0]       issue_rd;
    logic [CNT_W-1:0] count;

    modport master (
        output flush, in_valid, in_inst, in_rs1_tag, in_rs2_tag,
               fwd_valid, fwd_addr, fwd_data, issue_ready,
        input  in_ready, issue_valid, issue_aluin1, issue_aluin2,
               issue_memdata, issue_ctrl, issue_rd, count
    );

    modport slave (
        input  flush, in_valid, in_inst, in_rs1_tag, in_rs2_tag,
               fwd_valid, fwd_addr, fwd_data, issue_ready,
        output in_ready, issue_valid, issue_aluin1, issue_aluin2,
               issue_memdata, issue_ctrl, issue_rd, count
    );
endinterface

// File: rtl/reservation_station.sv
// Age-ordered compacting reservation station: holds waiting instructions, wakes them from the forwarding bus, issues oldest ready.
// Issue one cycle after enqueue/wakeup; in_ready depends only on registered occupancy, never on issue_ready.
module reservation_station #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reservation_station_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] memdata;
        logic [12:0] ctrl;
        logic [31:0] rs2_vt;
        logic        s2_valid;
        logic [31:0] rs1_vt;
        logic        s1_valid;
        logic [4:0]  rd;
    } pkt_t;

    typedef struct packed {
        logic       vld;
        pkt_t       pkt;
        logic [4:0] tag1;
        logic [4:0] tag2;
    } ent_t;

    ent_t             ent_q [DEPTH];
    ent_t             ent_d [DEPTH];
    ent_t             ext   [DEPTH+1];
    ent_t             enq_ent;
    ent_t             src;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] wr_pos;
    logic [DEPTH-1:0] rdy;
    logic [IDX_W-1:0] sel;
    logic             enq_fire, issue_fire;
    pkt_t             sel_pkt;

    // Stores keep their immediate in rs2_vt, so only memdata takes the forwarded value.
    function automatic ent_t wake(input ent_t e, input logic fv,
                                  input logic [4:0] fa, input logic [31:0] fd);
        ent_t r;
        r = e;
        if (fv && fa != 5'd0) begin
            if (!r.pkt.s1_valid && r.tag1 == fa) begin
                r.pkt.rs1_vt   = fd;
                r.pkt.s1_valid = 1'b1;
            end
            if (!r.pkt.s2_valid && r.tag2 == fa) begin
                r.pkt.memdata = fd;
                if (!r.pkt.ctrl[6])
                    r.pkt.rs2_vt = fd;
                r.pkt.s2_valid = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        rdy = '0;
        sel = '0;
        for (int i = 0; i < DEPTH; i++)
            rdy[i] = ent_q[i].vld & ent_q[i].pkt.s1_valid & ent_q[i].pkt.s2_valid;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (rdy[i])
                sel = IDX_W'(i);
    end

    always_comb begin
        sel_pkt = ent_q[sel].pkt;
        if (rdy == '0)
            sel_pkt = '0;
    end

    assign bus.issue_valid   = |rdy;
    assign bus.issue_aluin1  = sel_pkt.rs1_vt;
    assign bus.issue_aluin2  = sel_pkt.rs2_vt;
    assign bus.issue_memdata = sel_pkt.memdata;
    assign bus.issue_ctrl    = sel_pkt.ctrl;
    assign bus.issue_rd      = sel_pkt.rd;
    assign bus.in_ready      = (count_q < CNT_W'(DEPTH));
    assign bus.count         = count_q;

    assign enq_fire   = bus.in_valid & bus.in_ready & ~bus.flush;
    assign issue_fire = bus.issue_valid & bus.issue_ready & ~bus.flush;

    always_comb begin
        enq_ent = wake({1'b1, pkt_t'(bus.in_inst), bus.in_rs1_tag, bus.in_rs2_tag},
                       bus.fwd_valid, bus.fwd_addr, bus.fwd_data);
        wr_pos  = count_q - CNT_W'(issue_fire);
        for (int i = 0; i < DEPTH; i++)
            ext[i] = ent_q[i];
        ext[DEPTH] = '0;
        src = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // Entries at and above the issued slot slide down one place.
            if (issue_fire && i >= int'(sel))
                src = ext[i+1];
            else
                src = ext[i];
            ent_d[i] = wake(src, bus.fwd_valid, bus.fwd_addr, bus.fwd_data);
            if (enq_fire && CNT_W'(i) == wr_pos)
                ent_d[i] = enq_ent;
            if (bus.flush)
                ent_d[i].vld = 1'b0;
        end
        if (bus.flush)
            count_d = '0;
        else
            count_d = count_q + CNT_W'(enq_fire) - CNT_W'(issue_fire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                ent_q[i] <= '0;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++)
                ent_q[i] <= ent_d[i];
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: hand-computed vectors checked with immediate assertions.
module tb_reservation_station;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    reservation_station_if #(.CNT_W(3)) bus ();

    reservation_station #(.DEPTH(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [115:0] mk(input logic s1v, input logic [31:0] rs1,
                                        input logic s2v, input logic [31:0] rs2,
                                        input logic [4:0] rd, input logic [12:0] ctrl,
                                        input logic [31:0] mem);
        return {mem, ctrl, rs2, s2v, rs1, s1v, rd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        bus.flush = 0; bus.in_valid = 0; bus.in_inst = '0;
        bus.in_rs1_tag = 0; bus.in_rs2_tag = 0;
        bus.fwd_valid = 0; bus.fwd_addr = 0; bus.fwd_data = 0;
        bus.issue_ready = 0;
        #2;
        chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_aluin1", bus.issue_aluin1, 32'd0);
        tick(); tick();
        rst_n = 1'b1;

        // Fully valid packet issues the cycle after enqueue.
        bus.in_valid = 1; bus.in_inst = mk(1, 32'd5, 1, 32'd7, 5'd3, 13'h0, 32'h0);
        tick();
        bus.in_valid = 0;
        chk("t1_issue_valid", 32'(bus.issue_valid), 32'd1);
        chk("t1_aluin1", bus.issue_aluin1, 32'd5);
        chk("t1_aluin2", bus.issue_aluin2, 32'd7);
        chk("t1_rd", 32'(bus.issue_rd), 32'd3);
        chk("t1_count", 32'(bus.count), 32'd1);
        bus.issue_ready = 1;
        tick();
        bus.issue_ready = 0;
        chk("t1_count_after", 32'(bus.count), 32'd0);
        chk("t1_valid_after", 32'(bus.issue_valid), 32'd0);

        // Older unready A is skipped by younger ready B.
        bus.in_valid = 1; bus.in_inst = mk(0, 32'd0, 1, 32'd2, 5'd10, 13'h0, 32'h0);
        bus.in_rs1_tag = 5'd9;
        tick();
        bus.in_inst = mk(1, 32'h11, 1, 32'h22, 5'd11, 13'h0, 32'h0);
        bus.in_rs1_tag = 5'd0;
        tick();
        bus.in_valid = 0;
        chk("t2_count", 32'(bus.count), 32'd2);
        chk("t2_b_rd", 32'(bus.issue_rd), 32'd11);
        chk("t2_b_aluin1", bus.issue_aluin1, 32'h11);
        bus.issue_ready = 1;
        tick();
        bus.issue_ready = 0;
        chk("t2_a_waiting", 32'(bus.issue_valid), 32'd0);
        bus.fwd_valid = 1; bus.fwd_addr = 5'd9; bus.fwd_data = 32'h1234;
        #1;
        chk("t2_no_same_cycle_issue", 32'(bus.issue_valid), 32'd0);
        tick();
        bus.fwd_valid = 0;
        chk("t2_a_valid", 32'(bus.issue_valid), 32'd1);
        chk("t2_a_rd", 32'(bus.issue_rd), 32'd10);
        chk("t2_a_aluin1", bus.issue_aluin1, 32'h1234);
        chk("t2_a_aluin2", bus.issue_aluin2, 32'd2);
        bus.issue_ready = 1;
        tick();
        bus.issue_ready = 0;
        chk("t2_count_after", 32'(bus.count), 32'd0);

        // Store: immediate stays in rs2_vt, forwarded value lands in memdata.
        bus.in_valid = 1; bus.in_inst = mk(1, 32'h100, 0, 32'h10, 5'd0, 13'h0040, 32'h0);
        bus.in_rs2_tag = 5'd4;
        tick();
        bus.in_valid = 0; bus.in_rs2_tag = 5'd0;
        chk("t3_waiting", 32'(bus.issue_valid), 32'd0);
        bus.fwd_valid = 1; bus.fwd_addr = 5'd4; bus.fwd_data = 32'hAA;
        tick();
        bus.fwd_valid = 0;
        chk("t3_valid", 32'(bus.issue_valid), 32'd1);
        chk("t3_aluin2_imm", bus.issue_aluin2, 32'h10);
        chk("t3_memdata", bus.issue_memdata, 32'hAA);
        chk("t3_aluin1", bus.issue_aluin1, 32'h100);
        chk("t3_ctrl", 32'(bus.issue_ctrl), 32'h40);
        bus.issue_ready = 1;
        tick();
        bus.issue_ready = 0;
        chk("t3_count_after", 32'(bus.count), 32'd0);

        // Fill with unready entries while in_valid stays high.
        bus.in_valid = 1;
        for (int k = 0; k < 4; k++) begin
            bus.in_inst = mk(0, 32'd0, 1, 32'(k), 5'(k + 1), 13'h0, 32'h0);
            bus.in_rs1_tag = 5'(20 + k);
            tick();
        end
        bus.in_inst = mk(1, 32'h5, 1, 32'h6, 5'd21, 13'h0, 32'h0);
        bus.in_rs1_tag = 5'd0;
        chk("t4_full_count", 32'(bus.count), 32'd4);
        chk("t4_full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t4_full_none_ready", 32'(bus.issue_valid), 32'd0);
        bus.fwd_valid = 1; bus.fwd_addr = 5'd22; bus.fwd_data = 32'h77;
        tick();
        bus.fwd_valid = 0;
        chk("t4_refused_count", 32'(bus.count), 32'd4);
        chk("t4_woken_rd", 32'(bus.issue_rd), 32'd3);
        chk("t4_woken_aluin1", bus.issue_aluin1, 32'h77);
        bus.issue_ready = 1;
        tick();
        bus.issue_ready = 0;
        chk("t4_issue_while_full_count", 32'(bus.count), 32'd3);
        chk("t4_in_ready_back", 32'(bus.in_ready), 32'd1);
        chk("t4_rest_unready", 32'(bus.issue_valid), 32'd0);
        tick();
        bus.in_valid = 0;
        chk("t4_p5_count", 32'(bus.count), 32'd4);
        chk("t4_p5_rd", 32'(bus.issue_rd), 32'd21);
        bus.issue_ready = 1;
        tick();
        bus.issue_ready = 0;
        chk("t4_p5_gone_count", 32'(bus.count), 32'd3);
        chk("t4_p5_no_dup", 32'(bus.issue_valid), 32'd0);
        bus.fwd_valid = 1; bus.fwd_addr = 5'd21; bus.fwd_data = 32'h21;
        tick();
        bus.fwd_valid = 0;
        chk("t4_order_rd", 32'(bus.issue_rd), 32'd2);
        chk("t4_order_aluin2", bus.issue_aluin2, 32'd1);

        // Flush overrides simultaneous enqueue and issue.
        bus.flush = 1; bus.in_valid = 1; bus.issue_ready = 1;
        tick();
        bus.flush = 0; bus.in_valid = 0; bus.issue_ready = 0;
        chk("t6_flush_count", 32'(bus.count), 32'd0);
        chk("t6_flush_valid", 32'(bus.issue_valid), 32'd0);
        chk("t6_flush_in_ready", 32'(bus.in_ready), 32'd1);

        // Enqueue/broadcast bypass.
        bus.in_valid = 1; bus.in_inst = mk(0, 32'd0, 1, 32'h9, 5'd7, 13'h0, 32'h0);
        bus.in_rs1_tag = 5'd6;
        bus.fwd_valid = 1; bus.fwd_addr = 5'd6; bus.fwd_data = 32'h55;
        tick();
        bus.in_valid = 0; bus.fwd_valid = 0; bus.in_rs1_tag = 5'd0;
        chk("t5_bypass_valid", 32'(bus.issue_valid), 32'd1);
        chk("t5_bypass_aluin1", bus.issue_aluin1, 32'h55);
        chk("t5_bypass_rd", 32'(bus.issue_rd), 32'd7);
        bus.issue_ready = 1;
        tick();
        bus.issue_ready = 0;
        chk("t5_count_after", 32'(bus.count), 32'd0);

        // Register 0 broadcast never wakes.
        bus.in_valid = 1; bus.in_inst = mk(0, 32'd0, 1, 32'h1, 5'd8, 13'h0, 32'h0);
        bus.in_rs1_tag = 5'd0;
        bus.fwd_valid = 1; bus.fwd_addr = 5'd0; bus.fwd_data = 32'h99;
        tick();
        bus.in_valid = 0;
        chk("t5_r0_bypass", 32'(bus.issue_valid), 32'd0);
        chk("t5_r0_count", 32'(bus.count), 32'd1);
        tick();
        bus.fwd_valid = 0;
        chk("t5_r0_wake", 32'(bus.issue_valid), 32'd0);

        // Asynchronous reset mid-stream.
        bus.in_valid = 1; bus.in_inst = mk(1, 32'hA, 1, 32'hB, 5'd12, 13'h0, 32'h0);
        tick();
        bus.in_inst = mk(1, 32'hC, 1, 32'hD, 5'd13, 13'h0, 32'h0);
        tick();
        bus.in_valid = 0;
        chk("t7_pre_count", 32'(bus.count), 32'd3);
        chk("t7_pre_aluin1", bus.issue_aluin1, 32'hA);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", 32'(bus.issue_valid), 32'd0);
        chk("t7_rst_count", 32'(bus.count), 32'd0);
        chk("t7_rst_aluin1", bus.issue_aluin1, 32'd0);
        chk("t7_rst_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
